// File: rtl/canvas_port_arbiter.sv
// Canvas port A arbiter: compare stage has strict priority, clear engine sweeps idle cycles.
// Optional CANVAS_CLEAR_ON_RESET_EN: start a canvas wipe automatically out of reset.
module canvas_port_arbiter #(
    parameter int                ADDR_W      = 17,
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 76800,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              cmp_req_in,
    input  logic              cmp_we_in,
    input  logic [ADDR_W-1:0] cmp_addr_in,
    input  logic [DATA_W-1:0] cmp_din_in,
    input  logic              clear_req_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [DATA_W-1:0] bram_din_out,
    output logic              busy_out,
    output logic              clear_done_out,
    output logic [ADDR_W-1:0] clear_ptr_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

`ifdef CANVAS_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    localparam state_t RESET_STATE = ST_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] clear_ptr_r;
    logic [ADDR_W-1:0] ptr_next_s;
    logic [ADDR_W-1:0] bram_addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic              bram_we_r;
    logic              we_next_s;
    logic [DATA_W-1:0] bram_din_r;
    logic [DATA_W-1:0] din_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              done_r;
    logic              done_next_s;
    logic              clear_grant_s;

    // Port arbitration and clear-engine next-state logic
    always_comb begin
        next_state_s  = state_r;
        ptr_next_s    = clear_ptr_r;
        addr_next_s   = bram_addr_r;
        we_next_s     = 1'b0;
        din_next_s    = bram_din_r;
        clear_grant_s = 1'b0;

        // A restart request forfeits this cycle's clear slot
        if (cmp_req_in) begin
            addr_next_s = cmp_addr_in;
            we_next_s   = cmp_we_in;
            din_next_s  = cmp_din_in;
        end else if ((state_r == ST_CLEAR) && !clear_req_in) begin
            addr_next_s   = clear_ptr_r;
            we_next_s     = 1'b1;
            din_next_s    = CLEAR_VALUE;
            clear_grant_s = 1'b1;
        end else begin
            we_next_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (clear_req_in) begin
                    next_state_s = ST_CLEAR;
                    ptr_next_s   = ZERO_ADDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clear_req_in) begin
                    ptr_next_s = ZERO_ADDR;
                end else if (clear_grant_s) begin
                    if (clear_ptr_r == LAST_ADDR) begin
                        next_state_s = ST_DONE;
                        ptr_next_s   = ZERO_ADDR;
                    end else begin
                        ptr_next_s = clear_ptr_r + ADDR_W'(1);
                    end
                end else begin
                    ptr_next_s = clear_ptr_r;
                end
            end
            ST_DONE: begin
                if (clear_req_in) begin
                    next_state_s = ST_CLEAR;
                    ptr_next_s   = ZERO_ADDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                ptr_next_s   = ZERO_ADDR;
            end
        endcase

        busy_next_s = (next_state_s != ST_IDLE);
        done_next_s = (next_state_s == ST_DONE);
    end

    // State, pointer and registered BRAM port outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r     <= RESET_STATE;
            clear_ptr_r <= ZERO_ADDR;
            bram_addr_r <= ZERO_ADDR;
            bram_we_r   <= 1'b0;
            bram_din_r  <= ZERO_DATA;
            busy_r      <= RESET_BUSY;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            clear_ptr_r <= ptr_next_s;
            bram_addr_r <= addr_next_s;
            bram_we_r   <= we_next_s;
            bram_din_r  <= din_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
        end
    end

    assign bram_addr_out  = bram_addr_r;
    assign bram_we_out    = bram_we_r;
    assign bram_din_out   = bram_din_r;
    assign busy_out       = busy_r;
    assign clear_done_out = done_r;
    assign clear_ptr_out  = clear_ptr_r;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Self-checking bench for canvas_port_arbiter: constant vector table plus a
// reference-model scoreboard for sweep, restart, done-edge and async reset cases.
module tb_canvas_port_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 2000;

`ifdef CANVAS_CLEAR_ON_RESET_EN
    localparam int  RST_STATE = 1;
    localparam logic RST_BUSY = 1'b1;
`else
    localparam int  RST_STATE = 0;
    localparam logic RST_BUSY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmp_req;
    logic          cmp_we;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_din;
    logic          clear_req;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_din;
    logic          busy;
    logic          clear_done;
    logic [AW-1:0] clear_ptr;

    always #8 clk = ~clk;

    canvas_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_VALUE(8'h00)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .cmp_req_in(cmp_req), .cmp_we_in(cmp_we), .cmp_addr_in(cmp_addr),
        .cmp_din_in(cmp_din), .clear_req_in(clear_req),
        .bram_addr_out(bram_addr), .bram_we_out(bram_we), .bram_din_out(bram_din),
        .busy_out(busy), .clear_done_out(clear_done), .clear_ptr_out(clear_ptr)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] din;
        logic          busy;
        logic          done;
        logic [AW-1:0] ptr;
    } exp_t;

    typedef struct {
        logic          rq;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          clr;
        exp_t          exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[13];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model: 0 idle, 1 clear, 2 done
    int            m_state;
    logic [AW-1:0] m_ptr;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = RST_STATE;
        m_ptr   = '0;
        m_addr  = '0;
        m_we    = 1'b0;
        m_din   = '0;
    endtask

    task automatic model_step(input logic rq, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic clr, output exp_t e);
        logic wrote;
        wrote = 1'b0;
        if (rq) begin
            m_addr = a; m_we = we; m_din = d;
        end else if (m_state == 1 && !clr) begin
            m_addr = m_ptr; m_we = 1'b1; m_din = 8'h00; wrote = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (clr) begin
            m_state = 1; m_ptr = '0;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (wrote) begin
            if (m_ptr == AW'(DEPTH - 1)) begin
                m_state = 2; m_ptr = '0;
            end else begin
                m_ptr = m_ptr + 17'd1;
            end
        end
        e.addr = m_addr; e.we = m_we; e.din = m_din;
        e.busy = (m_state != 0); e.done = (m_state == 2); e.ptr = m_ptr;
    endtask

    task automatic drive_cycle(input logic rq, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic clr, input exp_t e);
        exp_t got;
        cmp_req = rq; cmp_we = we; cmp_addr = a; cmp_din = d; clear_req = clr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("bram_addr", 32'(bram_addr), 32'(got.addr));
        check("bram_we", 32'(bram_we), 32'(got.we));
        check("bram_din", 32'(bram_din), 32'(got.din));
        check("busy", 32'(busy), 32'(got.busy));
        check("clear_done", 32'(clear_done), 32'(got.done));
        check("clear_ptr", 32'(clear_ptr), 32'(got.ptr));
    endtask

    task automatic step(input logic rq, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic clr);
        exp_t e;
        model_step(rq, we, a, d, clr, e);
        drive_cycle(rq, we, a, d, clr, e);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b0);
    endtask

    task automatic run_to_idle(input string name);
        int n;
        n = 0;
        while (m_state != 0 && n < 4 * DEPTH) begin
            idle_step();
            n++;
        end
        check(name, 32'(m_state == 0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(bram_addr), 32'd0);
        check({tag, "_we"}, 32'(bram_we), 32'd0);
        check({tag, "_din"}, 32'(bram_din), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'(RST_BUSY));
        check({tag, "_done"}, 32'(clear_done), 32'd0);
        check({tag, "_ptr"}, 32'(clear_ptr), 32'd0);
    endtask

    function automatic vec_t mk(input logic rq, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic clr,
                                input logic [AW-1:0] ea, input logic ew, input logic [DW-1:0] ed,
                                input logic eb, input logic [AW-1:0] ep);
        vec_t v;
        v.rq = rq; v.we = we; v.addr = a; v.din = d; v.clr = clr;
        v.exp.addr = ea; v.exp.we = ew; v.exp.din = ed;
        v.exp.busy = eb; v.exp.done = 1'b0; v.exp.ptr = ep;
        return v;
    endfunction

    initial begin
        int   cnt;
        int   wr_cnt;
        int   done_cnt;
        exp_t e;

        // hand-computed vectors starting from IDLE
        tbl[0]  = mk(1'b1, 1'b1, 17'd1234, 8'hA5, 1'b0, 17'd1234, 1'b1, 8'hA5, 1'b0, 17'd0);
        tbl[1]  = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b0, 17'd1234, 1'b0, 8'hA5, 1'b0, 17'd0);
        tbl[2]  = mk(1'b1, 1'b0, 17'd77,   8'h3C, 1'b0, 17'd77,   1'b0, 8'h3C, 1'b0, 17'd0);
        tbl[3]  = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b1, 17'd77,   1'b0, 8'h3C, 1'b1, 17'd0);
        tbl[4]  = mk(1'b1, 1'b1, 17'd500,  8'h11, 1'b0, 17'd500,  1'b1, 8'h11, 1'b1, 17'd0);
        tbl[5]  = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b0, 17'd0,    1'b1, 8'h00, 1'b1, 17'd1);
        tbl[6]  = mk(1'b1, 1'b0, 17'd600,  8'h22, 1'b0, 17'd600,  1'b0, 8'h22, 1'b1, 17'd1);
        tbl[7]  = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b0, 17'd1,    1'b1, 8'h00, 1'b1, 17'd2);
        tbl[8]  = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b0, 17'd2,    1'b1, 8'h00, 1'b1, 17'd3);
        tbl[9]  = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b1, 17'd2,    1'b0, 8'h00, 1'b1, 17'd0);
        tbl[10] = mk(1'b1, 1'b1, 17'd5,    8'hFF, 1'b0, 17'd5,    1'b1, 8'hFF, 1'b1, 17'd0);
        tbl[11] = mk(1'b0, 1'b0, 17'd0,    8'h00, 1'b0, 17'd0,    1'b1, 8'h00, 1'b1, 17'd1);
        tbl[12] = mk(1'b1, 1'b1, 17'd9,    8'h44, 1'b1, 17'd9,    1'b1, 8'h44, 1'b1, 17'd0);

        rst_n = 1'b0; cmp_req = 1'b0; cmp_we = 1'b0; cmp_addr = '0; cmp_din = '0; clear_req = 1'b0;
        model_reset();
        #20;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_to_idle("startup_idle");

        for (int i = 0; i < 13; i++) begin
            model_step(tbl[i].rq, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].clr, e);
            drive_cycle(tbl[i].rq, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].clr, tbl[i].exp);
        end

        // finish the running sweep under random compare traffic
        cnt = 0; done_cnt = 0;
        while (m_state != 0 && cnt < 4 * DEPTH) begin
            step(($urandom_range(0, 2) == 0), 1'($urandom), AW'($urandom_range(0, DEPTH - 1)),
                 8'($urandom), 1'b0);
            if (clear_done) done_cnt++;
            cnt++;
        end
        check("traffic_sweep_end", 32'(m_state == 0), 32'd1);
        check("traffic_done_pulses", 32'(done_cnt), 32'd1);

        // clean wipe: exactly DEPTH ordered zero writes
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b1);
        check("wipe_busy_rise", 32'(busy), 32'd1);
        cnt = 0; wr_cnt = 0; done_cnt = 0;
        while (m_state != 0 && cnt < 2 * DEPTH) begin
            idle_step();
            if (bram_we && bram_addr == AW'(wr_cnt) && bram_din == 8'h00) wr_cnt++;
            if (clear_done) done_cnt++;
            cnt++;
        end
        check("wipe_write_count", 32'(wr_cnt), 32'(DEPTH));
        check("wipe_done_pulses", 32'(done_cnt), 32'd1);
        check("wipe_busy_fall", 32'(busy), 32'd0);

        // restart at pointer 500
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b1);
        cnt = 0;
        while (m_ptr != 17'd500 && cnt < 2 * DEPTH) begin
            idle_step();
            cnt++;
        end
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b1);
        cnt = 1;
        idle_step();
        check("restart_first_addr", 32'(bram_addr), 32'd0);
        cnt++;
        while (!clear_done && cnt < 2 * DEPTH) begin
            idle_step();
            cnt++;
        end
        check("restart_done_latency", 32'(cnt), 32'(DEPTH + 1));
        idle_step();

        // restart coincident with the DONE cycle
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b1);
        cnt = 0;
        while (m_state != 2 && cnt < 2 * DEPTH) begin
            idle_step();
            cnt++;
        end
        check("edge_done_seen", 32'(clear_done), 32'd1);
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b1);
        idle_step();
        check("edge_restart_addr0", 32'(bram_addr), 32'd0);
        run_to_idle("edge_sweep_end");

        // asynchronous reset mid-sweep
        step(1'b0, 1'b0, 17'd0, 8'h00, 1'b1);
        cnt = 0;
        while (m_ptr != 17'd300 && cnt < 2 * DEPTH) begin
            step(($urandom_range(0, 3) == 0), 1'b1, 17'd42, 8'h5A, 1'b0);
            cnt++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        #2;
        rst_n = 1'b1;
        idle_step();
        run_to_idle("post_reset_idle");
        step(1'b1, 1'b1, 17'd76799, 8'hC3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
